axis_spi_slave: RTL and testbench

SPI slave (target) core, the counterpart to the team's AXI-Stream SPI master; fixed CPOL=0, CPHA=1, MSB first, 8-bit frames. Oversamples SS/SCK/MOSI in the aclk domain, shifts received bytes out on M_AXIS and transmits bytes taken from S_AXIS on MISO. Sits between a board SPI port (external MCU/host as master) and fabric logic.

---
 rtl/axis_spi_slave_pkg.sv | 16 +
 rtl/axis_spi_slave_sync.sv | 44 ++++
 rtl/axis_spi_slave.sv | 159 +++++++++++++++
 tb/tb_axis_spi_slave.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_spi_slave_pkg.sv
// Shared constants and types for the AXI-Stream SPI slave (CPOL=0, CPHA=1,
// MSB first, 8-bit frames).
package axis_spi_slave_pkg;

  localparam int SPI_BITS = 8;
  localparam int CNT_W    = $clog2(SPI_BITS);

  localparam logic [SPI_BITS-1:0] DEFAULT_FILL_BYTE = 8'h00;

  // IDLE while slave select is high, ACTIVE while it is low.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/axis_spi_slave_sync.sv
// Brings one asynchronous SPI pin into the aclk domain and flags its edges.
// The edge flags are combinational from the last synchronizer stage and the
// edge-detect register, so an edge acted upon at the next clock lands
// SYNC_STAGES+1 cycles after the pin moved.
module axis_spi_slave_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the pin through the synchronizer; remember the last stage for edges.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-detect registers; reset to the pin's idle level so
  // leaving reset never fabricates an edge.
  // NOTE: clocked state is written only with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  =  level_o & ~prev_q;
  assign fall_o  = ~level_o &  prev_q;

endmodule

// File: rtl/axis_spi_slave.sv
// SPI slave core: receives MOSI bytes onto M_AXIS and transmits S_AXIS bytes
// on MISO. Mode 0/1 fixed to CPOL=0, CPHA=1: MISO changes on SCK rise, MOSI is
// captured on SCK fall. All pins are oversampled in the aclk domain.
module axis_spi_slave
  import axis_spi_slave_pkg::*;
#(
  parameter int                  SYNC_STAGES = 2,
  parameter logic [SPI_BITS-1:0] FILL_BYTE   = DEFAULT_FILL_BYTE
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                SS_I,
  input  logic                SCK_I,
  input  logic                IO0_I,
  output logic                IO1_O,
  output logic                IO1_T,
  input  logic [SPI_BITS-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [SPI_BITS-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                rx_overrun,
  output logic                tx_underrun
);

  logic ss_rise, ss_fall, ss_level_unused;
  logic sck_rise, sck_fall, sck_level_unused;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  axis_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(aclk), .rst_n(aresetn), .d_i(SS_I),
    .level_o(ss_level_unused), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  axis_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(aclk), .rst_n(aresetn), .d_i(SCK_I),
    .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  axis_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(aclk), .rst_n(aresetn), .d_i(IO0_I),
    .level_o(mosi), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  spi_state_e          state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SPI_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [SPI_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                miso_q, miso_d;
  logic                miso_t_q, miso_t_d;
  logic [SPI_BITS-1:0] m_tdata_q, m_tdata_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic                load_pt, byte_done, underrun, overrun;

  // Next-state logic: frame tracking, shifting, byte hand-off and reloads.
  // NOTE: every *_d and strobe gets a default before any branch so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    miso_d     = miso_q;
    miso_t_d   = miso_t_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    load_pt    = 1'b0;
    byte_done  = 1'b0;
    underrun   = 1'b0;
    overrun    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // SCK edges are ignored until the master selects us.
        if (ss_fall) begin
          state_d   = ST_ACTIVE;
          miso_t_d  = 1'b0;
          bit_cnt_d = '0;
          load_pt   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Deselect has priority over a coincident SCK edge; partial bytes in
        // both directions are abandoned.
        if (ss_rise) begin
          state_d    = ST_IDLE;
          miso_t_d   = 1'b1;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end else if (sck_rise) begin
          miso_d     = tx_shift_q[SPI_BITS-1];
          tx_shift_d = {tx_shift_q[SPI_BITS-2:0], 1'b0};
        end else if (sck_fall) begin
          rx_shift_d = {rx_shift_q[SPI_BITS-2:0], mosi};
          if (bit_cnt_q == CNT_W'(SPI_BITS - 1)) begin
            bit_cnt_d = '0;
            byte_done = 1'b1;
            load_pt   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load point: the next tx byte is in place before the next SCK rise.
    if (load_pt) begin
      tx_shift_d = s_axis_tvalid ? s_axis_tdata : FILL_BYTE;
      underrun   = ~s_axis_tvalid;
    end

    // Hand the completed byte downstream unless the holding slot is still
    // owned by an unaccepted beat, in which case the new byte is dropped.
    if (byte_done) begin
      if (!m_tvalid_q || m_axis_tready) begin
        m_tdata_d  = rx_shift_d;
        m_tvalid_d = 1'b1;
      end else begin
        overrun = 1'b1;
      end
    end else if (m_tvalid_q && m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      miso_q     <= 1'b0;
      miso_t_q   <= 1'b1;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      miso_q     <= miso_d;
      miso_t_q   <= miso_t_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign IO1_O         = miso_q;
  assign IO1_T         = miso_t_q;
  assign s_axis_tready = load_pt;
  assign tx_underrun   = underrun;
  assign rx_overrun    = overrun;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_axis_spi_slave.sv
// Bench for axis_spi_slave: a time-driven SPI master, S_AXIS/M_AXIS drivers,
// and a reference model built from pin history that is compared every cycle.
module tb_axis_spi_slave;

  localparam int         S    = 2;
  localparam logic [7:0] FILL = 8'h00;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       SS_I = 1'b1, SCK_I = 1'b0, IO0_I = 1'b0;
  logic       IO1_O, IO1_T;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       rx_overrun, tx_underrun;

  always #5 aclk = ~aclk;

  axis_spi_slave #(.SYNC_STAGES(S), .FILL_BYTE(FILL)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .SS_I(SS_I), .SCK_I(SCK_I), .IO0_I(IO0_I),
    .IO1_O(IO1_O), .IO1_T(IO1_T),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stream drivers ----------------
  logic [7:0] txq[$];
  bit         tx_en    = 1'b1;
  bit         rdy_rand = 1'b0;
  bit         rdy_val  = 1'b1;
  bit         tx_taken = 1'b0;

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (tx_taken && txq.size() > 0) void'(txq.pop_front());
      tx_taken      = 1'b0;
      s_axis_tvalid = tx_en && (txq.size() > 0);
      s_axis_tdata  = (txq.size() > 0) ? txq[0] : 8'h00;
      m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // ---------------- reference model + monitor ----------------
  logic       ss_h[0:S+1], sck_h[0:S+1], mosi_h[0:S+1];
  bit         m_active;
  bit         rx_bits[$];
  logic [7:0] m_tx;
  int         m_tx_idx;
  logic       m_miso, m_t;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       e_rdy, e_under, e_over;
  bit         ev_ss_fall, ev_ss_rise, ev_sck_rise, ev_sck_fall, done, load;
  int         byte_val;

  int         n_tready, n_hs, n_under, n_over;
  logic [7:0] beats[$];

  task automatic model_reset();
    for (int k = 0; k <= S + 1; k++) begin
      ss_h[k] = 1'b1; sck_h[k] = 1'b0; mosi_h[k] = 1'b0;
    end
    m_active = 1'b0; rx_bits.delete();
    m_tx = 8'h00; m_tx_idx = 8;
    m_miso = 1'b0; m_t = 1'b1; m_tdata = 8'h00; m_tvalid = 1'b0;
  endtask

  task automatic clear_counts();
    n_tready = 0; n_hs = 0; n_under = 0; n_over = 0;
    beats.delete();
  endtask

  function automatic logic [31:0] beat_at(input int i);
    return (i < beats.size()) ? {24'h0, beats[i]} : 32'hDEAD;
  endfunction

  initial begin
    model_reset();
    clear_counts();
    forever begin
      @(negedge aclk);
      e_rdy = 1'b0; e_under = 1'b0; e_over = 1'b0;
      if (!aresetn) model_reset();
      // Registered outputs reflect every clock edge up to now.
      check("io1_o", IO1_O, m_miso);
      check("io1_t", IO1_T, m_t);
      check("m_tvalid", m_axis_tvalid, m_tvalid);
      check("m_tdata", m_axis_tdata, m_tdata);
      if (aresetn) begin
        // Pin values that the coming edge will see, newest first.
        for (int k = S + 1; k > 0; k--) begin
          ss_h[k] = ss_h[k-1]; sck_h[k] = sck_h[k-1]; mosi_h[k] = mosi_h[k-1];
        end
        ss_h[0] = SS_I; sck_h[0] = SCK_I; mosi_h[0] = IO0_I;
        // An edge reaches the core SYNC_STAGES+1 clocks after the pin moved.
        ev_ss_fall  = !ss_h[S]  &&  ss_h[S+1];
        ev_ss_rise  =  ss_h[S]  && !ss_h[S+1];
        ev_sck_rise =  sck_h[S] && !sck_h[S+1];
        ev_sck_fall = !sck_h[S] &&  sck_h[S+1];
        done = 1'b0; load = 1'b0;
        if (!m_active) begin
          if (ev_ss_fall) begin
            m_active = 1'b1; m_t = 1'b0; rx_bits.delete(); load = 1'b1;
          end
        end else if (ev_ss_rise) begin
          m_active = 1'b0; m_t = 1'b1; rx_bits.delete();
        end else if (ev_sck_rise) begin
          m_miso = (m_tx_idx < 8) ? m_tx[7 - m_tx_idx] : 1'b0;
          m_tx_idx++;
        end else if (ev_sck_fall) begin
          rx_bits.push_back(mosi_h[S]);
          if (rx_bits.size() == 8) begin
            byte_val = 0;
            foreach (rx_bits[k]) byte_val = byte_val * 2 + int'(rx_bits[k]);
            rx_bits.delete();
            done = 1'b1; load = 1'b1;
          end
        end
        if (load) begin
          e_rdy = 1'b1;
          if (s_axis_tvalid) m_tx = s_axis_tdata;
          else begin m_tx = FILL; e_under = 1'b1; end
          m_tx_idx = 0;
        end
        if (done) begin
          if (!m_tvalid || m_axis_tready) begin
            m_tdata = byte_val[7:0]; m_tvalid = 1'b1;
          end else e_over = 1'b1;
        end else if (m_tvalid && m_axis_tready) m_tvalid = 1'b0;
      end
      check("s_tready", s_axis_tready, e_rdy);
      check("tx_underrun", tx_underrun, e_under);
      check("rx_overrun", rx_overrun, e_over);
      if (aresetn) begin
        n_tready += int'(s_axis_tready);
        n_under  += int'(tx_underrun);
        n_over   += int'(rx_overrun);
        if (s_axis_tready && s_axis_tvalid) begin n_hs++; tx_taken = 1'b1; end
        if (m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
      end
    end
  end

  // ---------------- SPI master ----------------
  int         half = 4;
  logic [7:0] miso_byte;

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  // Mode CPHA=1: drive MOSI on the rise, sample MISO just before the fall.
  task automatic spi_bits(input logic [7:0] b, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      SCK_I = 1'b1;
      IO0_I = b[7 - i];
      wait_cyc(half);
      miso_byte[7 - i] = IO1_O;
      SCK_I = 1'b0;
      wait_cyc(half);
    end
  endtask

  task automatic ss_begin();
    SS_I = 1'b0;
    wait_cyc(half);
  endtask

  task automatic ss_end();
    SS_I = 1'b1;
    wait_cyc(S + 4);
  endtask

  logic [7:0] got0, got1, got2;

  initial begin : watchdog
    #10ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nbytes;
    logic [7:0] b;
    // Reset state.
    wait_cyc(3);
    check("rst_io1_t", IO1_T, 1);
    check("rst_io1_o", IO1_O, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    aresetn = 1'b1;
    wait_cyc(3);

    // Single byte: 0xA5 out, 0x3C in; a spare byte covers the end-of-byte reload.
    txq = '{8'hA5, 8'hEE};
    wait_cyc(2);
    clear_counts();
    ss_begin(); spi_bits(8'h3C, 0, 8); got0 = miso_byte; ss_end();
    check("single_miso", got0, 8'hA5);
    check("single_nbeats", beats.size(), 1);
    check("single_beat", beat_at(0), 8'h3C);
    check("single_underrun", n_under, 0);

    // Back-to-back bytes in one select window.
    txq = '{8'h01, 8'h02, 8'h03, 8'hEE};
    wait_cyc(2);
    clear_counts();
    ss_begin();
    spi_bits(8'hF0, 0, 8); got0 = miso_byte;
    spi_bits(8'h0F, 0, 8); got1 = miso_byte;
    spi_bits(8'hAA, 0, 8); got2 = miso_byte;
    ss_end();
    check("b2b_miso0", got0, 8'h01);
    check("b2b_miso1", got1, 8'h02);
    check("b2b_miso2", got2, 8'h03);
    check("b2b_nbeats", beats.size(), 3);
    check("b2b_beat0", beat_at(0), 8'hF0);
    check("b2b_beat1", beat_at(1), 8'h0F);
    check("b2b_beat2", beat_at(2), 8'hAA);
    // Load points: select plus the end of each of the three bytes.
    check("b2b_tready_pulses", n_tready, 4);

    // Underrun at select, then 0x5A offered mid-byte goes out as byte two.
    txq.delete(); tx_en = 1'b0;
    wait_cyc(2);
    clear_counts();
    ss_begin();
    spi_bits(8'h96, 0, 4);
    txq.push_back(8'h5A); txq.push_back(8'hEE); tx_en = 1'b1;
    spi_bits(8'h96, 4, 4); got0 = miso_byte;
    spi_bits(8'h69, 0, 8); got1 = miso_byte;
    ss_end();
    check("under_miso0", got0, FILL);
    check("under_miso1", got1, 8'h5A);
    check("under_pulses", n_under, 1);

    // Overrun: downstream stalled across two bytes.
    rdy_val = 1'b0;
    txq = '{8'hEE, 8'hEE, 8'hEE};
    wait_cyc(2);
    clear_counts();
    ss_begin(); spi_bits(8'h11, 0, 8); spi_bits(8'h22, 0, 8); ss_end();
    check("over_tdata", m_axis_tdata, 8'h11);
    check("over_tvalid", m_axis_tvalid, 1);
    check("over_pulses", n_over, 1);
    rdy_val = 1'b1;
    wait_cyc(4);
    check("over_nbeats", beats.size(), 1);
    check("over_beat", beat_at(0), 8'h11);

    // Abort after five bits, then a clean 0x77.
    txq = '{8'hEE};
    wait_cyc(2);
    clear_counts();
    ss_begin(); spi_bits(8'hAB, 0, 5);
    SS_I = 1'b1;
    wait_cyc(S + 2);
    check("abort_io1_t", IO1_T, 1);
    wait_cyc(4);
    check("abort_nbeats", beats.size(), 0);
    txq = '{8'hEE, 8'hEE};
    ss_begin(); spi_bits(8'h77, 0, 8); ss_end();
    check("abort_next_nbeats", beats.size(), 1);
    check("abort_next_beat", beat_at(0), 8'h77);

    // Reset mid-byte, then a full 0xC3 exchange.
    txq = '{8'hEE};
    wait_cyc(2);
    ss_begin(); spi_bits(8'h5C, 0, 3);
    SCK_I = 1'b1; IO0_I = 1'b1;
    aresetn = 1'b0; SS_I = 1'b1; SCK_I = 1'b0;
    #1;
    check("mrst_io1_t", IO1_T, 1);
    check("mrst_io1_o", IO1_O, 0);
    check("mrst_m_tvalid", m_axis_tvalid, 0);
    check("mrst_m_tdata", m_axis_tdata, 0);
    check("mrst_tready", s_axis_tready, 0);
    wait_cyc(3);
    aresetn = 1'b1;
    txq = '{8'hC3, 8'hEE};
    wait_cyc(3);
    clear_counts();
    ss_begin(); spi_bits(8'hC3, 0, 8); got0 = miso_byte; ss_end();
    check("mrst_miso", got0, 8'hC3);
    check("mrst_nbeats", beats.size(), 1);
    check("mrst_beat", beat_at(0), 8'hC3);

    // Randomized traffic: varying SCK rate, backpressure, tx gaps and aborts.
    rdy_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      half = $urandom_range(4, 7);
      for (int k = $urandom_range(0, 3); k > 0; k--) txq.push_back(8'($urandom));
      tx_en = ($urandom_range(0, 3) != 0);
      nbytes = $urandom_range(1, 3);
      ss_begin();
      for (int j = 0; j < nbytes; j++) begin
        b = 8'($urandom);
        if (j == nbytes - 1 && $urandom_range(0, 5) == 0) spi_bits(b, 0, $urandom_range(1, 7));
        else spi_bits(b, 0, 8);
      end
      ss_end();
    end
    rdy_rand = 1'b0; rdy_val = 1'b1; tx_en = 1'b1; half = 4;
    wait_cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
